// File: rtl/rfsoc_config_pkg.sv
// Shared RFSoC PS-to-PL configuration constants: GPIO bus layout, register widths
// and the bit positions of every serial/control line on the PS GPIO bus.
package rfsoc_config;

   localparam int gpio_bus_width      = 16;
   localparam int config_reg_width    = 256;
   localparam int NCH_DEFAULT         = 16;
   localparam int ADC_SHIFT_W_DEFAULT = 8;

   localparam int GPIO_SDATA           = 0;
   localparam int GPIO_CYCLE_COUNT_CLK = 1;
   localparam int GPIO_PRE_DELAY_CLK   = 2;
   localparam int GPIO_POST_DELAY_CLK  = 3;
   localparam int GPIO_ADC_NUM_CLK     = 4;
   localparam int GPIO_ADC_SHIFT_CLK   = 5;
   localparam int GPIO_CHANNEL_SEL_CLK = 6;
   localparam int GPIO_MASK_CLK        = 7;
   localparam int GPIO_MUX_SET_CLK     = 8;
   localparam int GPIO_LOCK_CLK        = 9;
   localparam int GPIO_MASK_EN_CLK     = 10;
   localparam int GPIO_TRIGGER         = 11;
   localparam int GPIO_ADC_FLUSH       = 12;
   localparam int GPIO_PL_RST          = 13;

   // Serial clock for each wide timing register, in output order:
   // cycle_count, pre_delay, post_delay, adc_num_cycles.
   localparam int N_TIMING = 4;
   localparam int TIMING_CLK_IDX [N_TIMING] =
      '{GPIO_CYCLE_COUNT_CLK, GPIO_PRE_DELAY_CLK, GPIO_POST_DELAY_CLK, GPIO_ADC_NUM_CLK};

   // Serial clock for each per-channel strobe, in order: mask, mux, lock, mask_en.
   localparam int N_CH_STB = 4;
   localparam int CH_STB_CLK_IDX [N_CH_STB] =
      '{GPIO_MASK_CLK, GPIO_MUX_SET_CLK, GPIO_LOCK_CLK, GPIO_MASK_EN_CLK};

endpackage

// File: rtl/gpio_edge_sync.sv
// Per-bit 2-flop synchronizer followed by a delay stage for rising-edge detection.
module gpio_edge_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] i_async,
   output logic [W-1:0] o_sync,
   output logic [W-1:0] o_rise
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;
   logic [W-1:0] r_dly;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_meta <= '0;
         r_sync <= '0;
         r_dly  <= '0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_dly  <= r_sync;
      end
   end

   assign o_sync = r_sync;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_rise
         assign o_rise[gi] = r_sync[gi] & ~r_dly[gi];
      end
   endgenerate

endmodule

// File: rtl/gpio_cfg_decoder.sv
// Decodes the PS GPIO serial protocol into PL configuration registers,
// per-channel shift strobes and single-cycle event pulses.
module gpio_cfg_decoder
   import rfsoc_config::*;
#(
   parameter int NCH         = NCH_DEFAULT,
   parameter int ADC_SHIFT_W = ADC_SHIFT_W_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [gpio_bus_width-1:0]   gpio_in,
   output logic [config_reg_width-1:0] cycle_count,
   output logic [config_reg_width-1:0] pre_delay,
   output logic [config_reg_width-1:0] post_delay,
   output logic [config_reg_width-1:0] adc_num_cycles,
   output logic [ADC_SHIFT_W-1:0]      adc_shift_val,
   output logic [NCH-1:0]              channel_sel,
   output logic                        ch_sdata,
   output logic [NCH-1:0]              ch_mask_shift,
   output logic [NCH-1:0]              ch_mux_shift,
   output logic [NCH-1:0]              ch_lock_shift,
   output logic [NCH-1:0]              ch_mask_en_shift,
   output logic                        trigger_pulse,
   output logic                        adc_flush_pulse,
   output logic                        pl_rst_o
);

   logic [gpio_bus_width-1:0] w_sync;
   logic [gpio_bus_width-1:0] w_rise;
   logic                      w_sdata;
   logic                      w_pl_rst;

   logic [config_reg_width-1:0] r_timing [N_TIMING];
   logic [ADC_SHIFT_W-1:0]      r_adc_shift_val;
   logic [NCH-1:0]              r_channel_sel;
   logic [NCH-1:0]              r_ch_shift [N_CH_STB];
   logic                        r_ch_sdata;
   logic                        r_trigger_pulse;
   logic                        r_adc_flush_pulse;
   logic                        r_pl_rst_o;

   gpio_edge_sync #(
      .W (gpio_bus_width)
   ) u_edge_sync (
      .clk     (clk),
      .rstn    (rstn),
      .i_async (gpio_in),
      .o_sync  (w_sync),
      .o_rise  (w_rise)
   );

   // sdata comes from the same synchronized word as the serial clocks, so the
   // PS setup time on the bus carries straight through to the sample point.
   assign w_sdata  = w_sync[GPIO_SDATA];
   assign w_pl_rst = w_sync[GPIO_PL_RST];

   always_ff @(posedge clk) begin
      r_pl_rst_o <= w_pl_rst | ~rstn;
      if (!rstn || w_pl_rst) begin
         for (int i = 0; i < N_TIMING; i++) r_timing[i] <= '0;
         for (int i = 0; i < N_CH_STB; i++) r_ch_shift[i] <= '0;
         r_adc_shift_val   <= '0;
         r_channel_sel     <= '0;
         r_ch_sdata        <= 1'b0;
         r_trigger_pulse   <= 1'b0;
         r_adc_flush_pulse <= 1'b0;
      end else begin
         for (int i = 0; i < N_TIMING; i++) begin
            if (w_rise[TIMING_CLK_IDX[i]])
               r_timing[i] <= {r_timing[i][config_reg_width-2:0], w_sdata};
         end
         if (w_rise[GPIO_ADC_SHIFT_CLK])
            r_adc_shift_val <= {r_adc_shift_val[ADC_SHIFT_W-2:0], w_sdata};
         if (w_rise[GPIO_CHANNEL_SEL_CLK])
            r_channel_sel <= {r_channel_sel[NCH-2:0], w_sdata};
         // No one-hot check: every selected channel sees the strobe.
         for (int i = 0; i < N_CH_STB; i++)
            r_ch_shift[i] <= w_rise[CH_STB_CLK_IDX[i]] ? r_channel_sel : '0;
         r_ch_sdata        <= w_sdata;
         r_trigger_pulse   <= w_rise[GPIO_TRIGGER];
         r_adc_flush_pulse <= w_rise[GPIO_ADC_FLUSH];
      end
   end

   assign cycle_count      = r_timing[0];
   assign pre_delay        = r_timing[1];
   assign post_delay       = r_timing[2];
   assign adc_num_cycles   = r_timing[3];
   assign adc_shift_val    = r_adc_shift_val;
   assign channel_sel      = r_channel_sel;
   assign ch_sdata         = r_ch_sdata;
   assign ch_mask_shift    = r_ch_shift[0];
   assign ch_mux_shift     = r_ch_shift[1];
   assign ch_lock_shift    = r_ch_shift[2];
   assign ch_mask_en_shift = r_ch_shift[3];
   assign trigger_pulse    = r_trigger_pulse;
   assign adc_flush_pulse  = r_adc_flush_pulse;
   assign pl_rst_o         = r_pl_rst_o;

endmodule

// File: tb/tb_gpio_cfg_decoder.sv
// Scoreboard bench for gpio_cfg_decoder: serial register loads, channel strobes,
// event pulses, soft reset and hard reset behaviour.
module tb_gpio_cfg_decoder;
   import rfsoc_config::*;

   localparam int CW = config_reg_width;

   logic                      clk  = 1'b0;
   logic                      rstn = 1'b0;
   logic [gpio_bus_width-1:0] gpio_in = '0;

   logic [CW-1:0] cycle_count, pre_delay, post_delay, adc_num_cycles;
   logic [7:0]    adc_shift_val;
   logic [15:0]   channel_sel, ch_mask_shift, ch_mux_shift, ch_lock_shift, ch_mask_en_shift;
   logic          ch_sdata, trigger_pulse, adc_flush_pulse, pl_rst_o;

   always #5 clk = ~clk;

   gpio_cfg_decoder #(
      .NCH         (16),
      .ADC_SHIFT_W (8)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .gpio_in          (gpio_in),
      .cycle_count      (cycle_count),
      .pre_delay        (pre_delay),
      .post_delay       (post_delay),
      .adc_num_cycles   (adc_num_cycles),
      .adc_shift_val    (adc_shift_val),
      .channel_sel      (channel_sel),
      .ch_sdata         (ch_sdata),
      .ch_mask_shift    (ch_mask_shift),
      .ch_mux_shift     (ch_mux_shift),
      .ch_lock_shift    (ch_lock_shift),
      .ch_mask_en_shift (ch_mask_en_shift),
      .trigger_pulse    (trigger_pulse),
      .adc_flush_pulse  (adc_flush_pulse),
      .pl_rst_o         (pl_rst_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Output monitor: counts strobes and records when they occurred.
   int          cyc = 0;
   int          trig_cnt = 0, trig_last = -1, flush_cnt = 0;
   int          stb_cnt [4] = '{0, 0, 0, 0};
   logic [15:0] stb_val [4];
   logic        stb_sd  [4];
   int          rst_cyc = 0, rst_bad = 0;
   logic        rst_sampled = 1'b0;

   always @(posedge clk) rst_sampled <= !rstn;

   always @(negedge clk) begin
      logic [15:0] s [4];
      cyc++;
      s = '{ch_mask_shift, ch_mux_shift, ch_lock_shift, ch_mask_en_shift};
      if (trigger_pulse) begin
         trig_cnt++;
         trig_last = cyc;
      end
      if (adc_flush_pulse) flush_cnt++;
      for (int i = 0; i < 4; i++) begin
         if (s[i] != 16'h0) begin
            stb_cnt[i]++;
            stb_val[i] = s[i];
            stb_sd[i]  = ch_sdata;
         end
      end
      if (rst_sampled) begin
         rst_cyc++;
         if (pl_rst_o !== 1'b1 ||
             (|{cycle_count, pre_delay, post_delay, adc_num_cycles, adc_shift_val, channel_sel,
                ch_sdata, ch_mask_shift, ch_mux_shift, ch_lock_shift, ch_mask_en_shift,
                trigger_pulse, adc_flush_pulse}) !== 1'b0)
            rst_bad++;
      end
   end

   // Reference model of the six configuration registers.
   logic [CW-1:0] m_tim [4];
   logic [7:0]    m_shift;
   logic [15:0]   m_chsel;
   logic          m_plrst = 1'b0;

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_tim[i] = '0;
      m_shift = '0;
      m_chsel = '0;
   endtask

   typedef struct {
      string         tag;
      int            obs;
      logic [CW-1:0] exp;
   } exp_t;
   exp_t sb [$];

   function automatic logic [CW-1:0] observe(input int id);
      case (id)
         0:       return cycle_count;
         1:       return pre_delay;
         2:       return post_delay;
         3:       return adc_num_cycles;
         4:       return CW'(adc_shift_val);
         default: return CW'(channel_sel);
      endcase
   endfunction

   task automatic push_all(input string tag);
      string nm [6] = '{"cyc", "pre", "post", "adcn", "shift", "chsel"};
      for (int i = 0; i < 6; i++) begin
         exp_t e;
         e.tag = {tag, "_", nm[i]};
         e.obs = i;
         e.exp = (i < 4) ? m_tim[i] : (i == 4) ? CW'(m_shift) : CW'(m_chsel);
         sb.push_back(e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      tick(4);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check_val(e.tag, observe(e.obs), e.exp);
      end
   endtask

   // One serial bit: sdata set up well ahead of the serial clock(s) in clk_mask.
   task automatic send_bit(input logic [gpio_bus_width-1:0] clk_mask, input logic b);
      gpio_in[GPIO_SDATA] = b;
      tick(3);
      gpio_in = gpio_in | clk_mask;
      tick(3);
      gpio_in = gpio_in & ~clk_mask;
      tick(2);
      if (!m_plrst) begin
         if (clk_mask[GPIO_CYCLE_COUNT_CLK]) m_tim[0] = {m_tim[0][CW-2:0], b};
         if (clk_mask[GPIO_PRE_DELAY_CLK])   m_tim[1] = {m_tim[1][CW-2:0], b};
         if (clk_mask[GPIO_POST_DELAY_CLK])  m_tim[2] = {m_tim[2][CW-2:0], b};
         if (clk_mask[GPIO_ADC_NUM_CLK])     m_tim[3] = {m_tim[3][CW-2:0], b};
         if (clk_mask[GPIO_ADC_SHIFT_CLK])   m_shift  = {m_shift[6:0], b};
         if (clk_mask[GPIO_CHANNEL_SEL_CLK]) m_chsel  = {m_chsel[14:0], b};
      end
   endtask

   task automatic send_word(input logic [gpio_bus_width-1:0] clk_mask,
                            input logic [31:0] value, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(clk_mask, value[i]);
   endtask

   function automatic logic [gpio_bus_width-1:0] bitm(input int idx);
      return gpio_bus_width'(1) << idx;
   endfunction

   initial begin
      int t0, t_cap, c0, f0;
      int s0 [4];
      logic b;

      model_clear();

      // Hard reset
      tick(5);
      check_val("rst_pl_rst_o", CW'(pl_rst_o), CW'(1));
      rstn = 1'b1;
      tick(4);
      check_val("rel_pl_rst_o", CW'(pl_rst_o), CW'(0));
      check_val("rst_outs_bad", CW'(rst_bad), CW'(0));
      push_all("init");
      drain();

      // 0xA5 into adc_shift_val, nothing else moves
      send_word(bitm(GPIO_ADC_SHIFT_CLK), 32'hA5, 8);
      push_all("a5");
      drain();

      // 260 alternating bits: only the last 256 survive
      for (int k = 0; k < 260; k++) send_bit(bitm(GPIO_CYCLE_COUNT_CLK), 1'(k % 2));
      push_all("ovf");
      drain();
      check_val("ovf_pattern", cycle_count, {64{4'h5}});

      // Simultaneous serial clocks share one sdata stream
      send_word(bitm(GPIO_PRE_DELAY_CLK) | bitm(GPIO_POST_DELAY_CLK), 32'h1234, 16);
      push_all("dual");
      drain();

      // Channel select, then each per-channel strobe once
      send_word(bitm(GPIO_CHANNEL_SEL_CLK), 32'h0005, 16);
      push_all("chsel");
      drain();
      for (int s = 0; s < 4; s++) begin
         s0 = stb_cnt;
         b  = (s % 2 == 0);
         send_bit(bitm(CH_STB_CLK_IDX[s]), b);
         tick(2);
         check_val($sformatf("stb%0d_cnt", s), CW'(stb_cnt[s] - s0[s]), CW'(1));
         check_val($sformatf("stb%0d_val", s), CW'(stb_val[s]), CW'(16'h0005));
         check_val($sformatf("stb%0d_sd", s), CW'(stb_sd[s]), CW'(b));
      end
      push_all("after_stb");
      drain();

      // Trigger held high 50 cycles: one pulse, visible after capture edge + 2
      c0 = trig_cnt;
      gpio_in[GPIO_TRIGGER] = 1'b1;
      t_cap = cyc + 2;
      tick(50);
      gpio_in[GPIO_TRIGGER] = 1'b0;
      tick(4);
      check_val("trig_cnt", CW'(trig_cnt - c0), CW'(1));
      check_val("trig_lat", CW'(trig_last), CW'(t_cap + 2));

      f0 = flush_cnt;
      gpio_in[GPIO_ADC_FLUSH] = 1'b1;
      tick(10);
      gpio_in[GPIO_ADC_FLUSH] = 1'b0;
      tick(4);
      check_val("flush_cnt", CW'(flush_cnt - f0), CW'(1));

      // Soft reset: clears, ignores serial edges, no edge for lines high at release
      c0 = trig_cnt;
      s0 = stb_cnt;
      m_plrst = 1'b1;
      model_clear();
      gpio_in[GPIO_PL_RST]  = 1'b1;
      gpio_in[GPIO_TRIGGER] = 1'b1;
      tick(3);
      send_bit(bitm(GPIO_CYCLE_COUNT_CLK) | bitm(GPIO_MASK_CLK), 1'b1);
      check_val("plrst_o_hi", CW'(pl_rst_o), CW'(1));
      check_val("plrst_pre", pre_delay, '0);
      check_val("plrst_cyc", cycle_count, '0);
      gpio_in[GPIO_PL_RST] = 1'b0;
      m_plrst = 1'b0;
      tick(6);
      gpio_in[GPIO_TRIGGER] = 1'b0;
      tick(4);
      check_val("plrst_o_lo", CW'(pl_rst_o), CW'(0));
      check_val("plrst_trig", CW'(trig_cnt - c0), CW'(0));
      check_val("plrst_stb", CW'(stb_cnt[0] - s0[0]), CW'(0));
      push_all("plrst");
      drain();

      // Hard reset mid-shift with trigger held through release
      send_word(bitm(GPIO_ADC_SHIFT_CLK), 32'hC, 4);
      push_all("partial");
      drain();
      c0 = trig_cnt;
      f0 = rst_cyc;
      gpio_in[GPIO_TRIGGER] = 1'b1;
      rstn = 1'b0;
      tick(4);
      rstn = 1'b1;
      t_cap = cyc + 2;
      model_clear();
      tick(8);
      gpio_in[GPIO_TRIGGER] = 1'b0;
      tick(4);
      check_val("rst2_cycles", CW'(rst_cyc - f0), CW'(4));
      check_val("rst2_outs_bad", CW'(rst_bad), CW'(0));
      check_val("rst2_trig_cnt", CW'(trig_cnt - c0), CW'(1));
      check_val("rst2_trig_lat", CW'(trig_last), CW'(t_cap + 2));
      push_all("rst2");
      drain();

      // All-zero channel_sel selects nothing
      s0 = stb_cnt;
      send_bit(bitm(GPIO_MASK_CLK), 1'b1);
      tick(2);
      check_val("zero_sel_stb", CW'(stb_cnt[0] - s0[0]), CW'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gpio_cfg_decoder.md
GPIO_CFG_DECODER -- requirements
Module: gpio_cfg_decoder

Interface
REQ-001 SHALL take parameter NCH, default 16: channel count, equal to the channel_sel register width.
REQ-002 SHALL take parameter ADC_SHIFT_W, default 8: width of the ADC averaging shift value.
REQ-003 SHALL have port clk, input, 1: single fabric clock for all logic.
REQ-004 SHALL have port rstn, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port gpio_in, input, gpio_bus_width: asynchronous PS GPIO bus, bit map per package indices.
REQ-006 SHALL have ports cycle_count, pre_delay, post_delay and adc_num_cycles, outputs, config_reg_width each: DAC/ADC timing registers.
REQ-007 SHALL have port adc_shift_val, output, ADC_SHIFT_W: ADC averaging exponent.
REQ-008 SHALL have port channel_sel, output, NCH: one-hot channel selection register.
REQ-009 SHALL have port ch_sdata, output, 1: serial data bit forwarded to per-channel shifters.
REQ-010 SHALL have ports ch_mask_shift, ch_mux_shift, ch_lock_shift and ch_mask_en_shift, outputs, NCH each: per-channel single-cycle shift enables.
REQ-011 SHALL have ports trigger_pulse and adc_flush_pulse, outputs, 1 each: single-cycle event strobes.
REQ-012 SHALL have port pl_rst_o, output, 1: fabric soft-reset level for downstream blocks.

Function
REQ-013 SHALL pass gpio_in through a 2-flop synchronizer, then a delay register, for rising-edge detection on every line.
REQ-014 SHALL count a rising edge only when synchronized bit = 1 and delayed bit = 0.
REQ-015 SHALL sample sdata from the same synchronized word as the clock edge; the PS protocol requires sdata stable at least 2 clk periods before its serial clock rises.
REQ-016 SHALL, on a cycle_count_clk, pre_delay_cycle_clk, post_delay_cycle_clk, adc_num_cycle_count_clk, adc_shift_val_clk or channel_sel_clk edge, shift the matching register left by one, with sdata entering the LSB (MSB-first transmission).
REQ-017 SHALL drop the MSB on overflow; shifting more bits than the register width keeps only the last W bits.
REQ-018 SHALL let simultaneous edges on several serial clocks each shift the same sdata bit into their own register in the same cycle.
REQ-019 SHALL, on a mask_clk, mux_set_clk, locking_waveform_clk or mask_enable_clk edge, assert the matching ch_*_shift[i] for exactly one cycle for every i where channel_sel[i] = 1.
REQ-020 SHALL register ch_sdata as the sampled sdata in the same cycle as the ch_*_shift strobes.
REQ-021 SHALL not check channel_sel for one-hot encoding: all-zero selects no channel, and multiple bits broadcast to all selected channels.
REQ-022 SHALL assert trigger_pulse for one cycle per trigger_line rising edge, and adc_flush_pulse likewise per adc_buffer_flush rising edge; a held-high level yields one pulse only.
REQ-023 SHALL keep latency fixed: a gpio_in change captured at clk edge N affects registers and strobes after edge N+2.
REQ-024 SHALL drive pl_rst_o as a registered (synchronized pl_rst OR NOT rstn).
REQ-025 SHALL, while synchronized pl_rst = 1, clear all config registers, hold them at 0, force all strobes to 0 and ignore serial clock edges.
REQ-026 SHALL, when pl_rst falls, require a fresh rising edge; lines already high at release produce no edge.

Reset
REQ-027 SHALL, while rstn = 0 at a clk edge, clear synchronizers, delay register, all config registers and all strobes to 0, and set pl_rst_o = 1.
REQ-028 SHALL treat reset mid-shift as a discard: a partially shifted word is lost and the PS reloads all registers.
REQ-029 SHALL clear the delay register to 0 on reset, so a line held high through reset release produces exactly one edge 2 cycles later.

Structure
REQ-030 SHALL take gpio_bus_width, config_reg_width and the GPIO bit indices from the shared rfsoc_config package, and SHALL add NCH and ADC_SHIFT_W defaults there.
REQ-031 SHALL use one generic sub-module, gpio_edge_sync, providing a per-bit 2-flop synchronizer plus rising-edge detector, instantiated once over the whole bus.

Verification
REQ-032 Shift 0xA5 MSB-first on adc_shift_val_clk -> adc_shift_val = 0xA5; no other register changes.
REQ-033 Shift 260 bits on cycle_count_clk, with bit k = k mod 2 -> cycle_count holds the last 256 bits; first 4 bits lost.
REQ-034 channel_sel = 0x0005, one mask_clk edge with sdata = 1 -> ch_mask_shift = 0x0005 for 1 cycle, ch_sdata = 1.
REQ-035 Hold trigger_line high 50 cycles -> exactly one trigger_pulse, after edge N+2.
REQ-036 Load pre_delay = 0x1234, then raise pl_rst for 10 cycles -> pl_rst_o high, pre_delay = 0, shift edges during pl_rst ignored.
REQ-037 rstn low mid-shift with trigger_line high through release -> all outputs 0 during reset; one trigger_pulse 2 cycles after release.
